// File: rtl/sample_pkg.sv
// Shared types and constants for the sample framer.
// Packed word layout on the filter side: {p[1:0], t[1:0], y[1:0], x[1:0]}.
// Optional feature macro used elsewhere: FRAMER_HOLD_EN.
package sample_pkg;

  // One sample as carried through the FIFO; packs to {t,y,x}.
  typedef struct packed {
    logic [1:0] t;
    logic [1:0] y;
    logic [1:0] x;
  } sample_t;

  // Framing marker for the two-bit p field.
  localparam logic [1:0] P_LIVE = 2'b11;
  localparam logic [1:0] P_IDLE = 2'b00;

  // Emission engine states, kept as plain constants so the state vector
  // can be exported unchanged on the debug port.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Build an output word from a framing marker and a sample.
  function automatic logic [7:0] pack_word(input logic [1:0] p, input sample_t s);
    return {p, s};
  endfunction

endpackage

// File: rtl/sample_framer_if.sv
// Bundle of the producer-side handshake and the filter-side word stream of
// the sample framer. master = the block driving samples (and enable),
// slave = the framer itself.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on registered occupancy, never
// on in_valid or on a pop in the same cycle; the producer may hold in_valid
// and the in_* fields steady until the transfer edge.
interface sample_framer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_x;
  logic [1:0]       in_y;
  logic [1:0]       in_t;
  logic             enable;
  logic [7:0]       word_out;
  logic             word_strobe;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] underflow_cnt;

  modport master (
    output in_valid, in_x, in_y, in_t, enable,
    input  in_ready, word_out, word_strobe, fifo_level, underflow_cnt
  );

  modport slave (
    input  in_valid, in_x, in_y, in_t, enable,
    output in_ready, word_out, word_strobe, fifo_level, underflow_cnt
  );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO. The head entry is read straight from the
// storage registers, so it is valid in the same cycle the level says it is
// there. The caller guarantees push only when not full and pop only when
// not empty.
module sample_fifo
  import sample_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  sample_t                din,
  output sample_t                dout,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  sample_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + 1'b1;
    end else if (pop && !push) begin
      level <= level - 1'b1;
    end
  end

  assign dout = mem[rd_ptr];

  assert property (@(posedge clk) disable iff (reset) !(pop && level == '0));
  assert property (@(posedge clk) disable iff (reset)
                   !(push && !pop && level == ($clog2(DEPTH)+1)'(DEPTH)));

endmodule

// File: rtl/sample_framer.sv
// Sample framer: buffers x/y/t samples from a producer and emits one packed
// {p,t,y,x} word per pacing slot toward the windowed-sum filter.
// Build option FRAMER_HOLD_EN: an empty slot repeats the last live word
// instead of emitting the idle word 8'h00.
module sample_framer
  import sample_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SAMPLE_PERIOD = 4,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           reset,
  sample_framer_if.slave bus,
  output logic [0:0]     fsm_state
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PACE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [PACE_W-1:0] PACE_LAST  = PACE_W'(SAMPLE_PERIOD - 1);

  logic [0:0]        state;
  logic [PACE_W-1:0] pace;
  logic [LVL_W-1:0]  level;
  sample_t           in_sample;
  sample_t           head;
  logic              push;
  logic              pop;
  logic              slot;
  logic              has_data;
  logic [7:0]        idle_word;
  logic [7:0]        word_q;
  logic              strobe_q;
  logic [CNT_W-1:0]  under_q;

  assign in_sample.t = bus.in_t;
  assign in_sample.y = bus.in_y;
  assign in_sample.x = bus.in_x;

  // Ready comes from the registered level only, so a pop this cycle does
  // not open room until the next one.
  assign bus.in_ready = (level < FULL_LEVEL);
  assign push         = bus.in_valid && bus.in_ready;

  // A slot needs RUN and enable still high; dropping enable wins over a slot.
  assign slot     = (state == ST_RUN) && bus.enable && (pace == PACE_LAST);
  assign has_data = (level != '0);
  assign pop      = slot && has_data;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_sample),
    .dout  (head),
    .level (level)
  );

  // Emission engine state: IDLE until enabled, back to IDLE as soon as
  // enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.enable)  state <= ST_RUN;
        ST_RUN:  if (!bus.enable) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pace counter: counts 0..SAMPLE_PERIOD-1 while running, held at 0 otherwise,
  // so the first slot always lands SAMPLE_PERIOD cycles after entering RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      pace <= '0;
    end else if ((state == ST_RUN) && bus.enable) begin
      pace <= slot ? '0 : pace + 1'b1;
    end else begin
      pace <= '0;
    end
  end

`ifdef FRAMER_HOLD_EN
  logic [7:0] last_word;

  // Remember the most recent live word for re-emission on empty slots;
  // cleared on reset so nothing stale survives a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_word <= 8'h00;
    end else if (pop) begin
      last_word <= pack_word(P_LIVE, head);
    end
  end

  assign idle_word = last_word;
`else
  assign idle_word = pack_word(P_IDLE, '0);
`endif

  // Output register: one-cycle word per slot, idle word everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q   <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= slot;
      if (slot) begin
        word_q <= has_data ? pack_word(P_LIVE, head) : idle_word;
      end else begin
        word_q <= 8'h00;
      end
    end
  end

  // Saturating count of slots that found the FIFO empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      under_q <= '0;
    end else if (slot && !has_data && (under_q != '1)) begin
      under_q <= under_q + 1'b1;
    end
  end

  assign bus.word_out      = word_q;
  assign bus.word_strobe   = strobe_q;
  assign bus.fifo_level    = level;
  assign bus.underflow_cnt = under_q;
  assign fsm_state         = state;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer. Two instances share clock and reset:
// dut_a paces at SAMPLE_PERIOD=4, dut_b at SAMPLE_PERIOD=1.
// Expectations follow the FRAMER_HOLD_EN build option when it is defined.
module tb_sample_framer;

  logic       clk;
  logic       reset;
  logic [0:0] a_state;
  logic [0:0] b_state;

  int vectors;
  int miscompares;

  logic [7:0] exp_q[$];

`ifdef FRAMER_HOLD_EN
  localparam logic [7:0] HOLD_EXP = 8'hE4;
`else
  localparam logic [7:0] HOLD_EXP = 8'h00;
`endif

  sample_framer_if #(.FIFO_DEPTH(4), .CNT_W(8)) a_if ();
  sample_framer_if #(.FIFO_DEPTH(4), .CNT_W(8)) b_if ();

  sample_framer #(.FIFO_DEPTH(4), .SAMPLE_PERIOD(4), .CNT_W(8)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (a_if),
    .fsm_state (a_state)
  );

  sample_framer #(.FIFO_DEPTH(4), .SAMPLE_PERIOD(1), .CNT_W(8)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (b_if),
    .fsm_state (b_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change on the falling edge only.
  task automatic drive_a(input logic v, input logic [5:0] s);
    a_if.in_valid = v;
    a_if.in_t     = s[5:4];
    a_if.in_y     = s[3:2];
    a_if.in_x     = s[1:0];
  endtask

  task automatic drive_b(input logic v, input logic [5:0] s);
    b_if.in_valid = v;
    b_if.in_t     = s[5:4];
    b_if.in_y     = s[3:2];
    b_if.in_x     = s[1:0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b1;
    a_if.enable = 1'b0;
    b_if.enable = 1'b0;
    drive_a(1'b0, 6'h00);
    drive_b(1'b0, 6'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (a_if.word_out !== 8'h00 || a_if.word_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_word got %h/%b exp 00/0", a_if.word_out, a_if.word_strobe);
    end
    vectors++;
    if (a_if.fifo_level !== 3'd0 || a_if.underflow_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_level_cnt got %0d/%0d exp 0/0", a_if.fifo_level, a_if.underflow_cnt);
    end
    vectors++;
    if (a_if.in_ready !== 1'b1 || a_state !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_state got %b/%b exp 1/0", a_if.in_ready, a_state);
    end
  endtask

  task automatic test_single_live();
    apply_reset();
    a_if.enable = 1'b1;
    drive_a(1'b1, 6'h39);           // t=3 y=2 x=1
    @(negedge clk);
    drive_a(1'b0, 6'h00);
    vectors++;
    if (a_if.fifo_level !== 3'd1 || a_state !== 1'b1) begin
      miscompares++;
      $display("FAIL single_entry got lvl %0d st %b exp 1/1", a_if.fifo_level, a_state);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (a_if.word_strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL single_early_strobe cycle %0d got %b exp 0", k, a_if.word_strobe);
      end
    end
    @(negedge clk);
    vectors++;
    if (a_if.word_strobe !== 1'b1 || a_if.word_out !== 8'hF9 || a_if.fifo_level !== 3'd0) begin
      miscompares++;
      $display("FAIL single_word got %b/%h/%0d exp 1/f9/0",
               a_if.word_strobe, a_if.word_out, a_if.fifo_level);
    end
    a_if.enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_if.word_strobe !== 1'b0 || a_if.word_out !== 8'h00 || a_if.underflow_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL single_after got %b/%h/%0d exp 0/00/0",
               a_if.word_strobe, a_if.word_out, a_if.underflow_cnt);
    end
  endtask

  task automatic test_fill_full();
    logic [5:0] fill_s [5];
    logic [7:0] fill_w [5];
    fill_s = '{6'h01, 6'h12, 6'h23, 6'h34, 6'h2D};
    fill_w = '{8'hC1, 8'hD2, 8'hE3, 8'hF4, 8'hED};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, fill_s[k]);
      @(negedge clk);
      vectors++;
      if (a_if.fifo_level !== 3'((k < 4) ? k + 1 : 4) || a_if.in_ready !== (k < 3)) begin
        miscompares++;
        $display("FAIL fill_level push %0d got %0d/%b exp %0d/%b", k,
                 a_if.fifo_level, a_if.in_ready, (k < 4) ? k + 1 : 4, (k < 3));
      end
    end
    a_if.enable = 1'b1;             // 5th sample still offered
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (a_if.fifo_level !== 3'd4 || a_if.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_held cycle %0d got %0d/%b exp 4/0", c, a_if.fifo_level, a_if.in_ready);
      end
    end
    @(negedge clk);
    vectors++;
    if (a_if.word_strobe !== 1'b1 || a_if.word_out !== fill_w[0] ||
        a_if.fifo_level !== 3'd3 || a_if.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_first_pop got %b/%h/%0d/%b exp 1/c1/3/1",
               a_if.word_strobe, a_if.word_out, a_if.fifo_level, a_if.in_ready);
    end
    @(negedge clk);
    drive_a(1'b0, 6'h00);
    vectors++;
    if (a_if.fifo_level !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_fifth_push got %0d exp 4", a_if.fifo_level);
    end
    for (int w = 1; w < 5; w++) begin
      repeat ((w == 1) ? 3 : 4) @(negedge clk);
      vectors++;
      if (a_if.word_strobe !== 1'b1 || a_if.word_out !== fill_w[w]) begin
        miscompares++;
        $display("FAIL fill_order word %0d got %b/%h exp 1/%h",
                 w, a_if.word_strobe, a_if.word_out, fill_w[w]);
      end
    end
    a_if.enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_if.fifo_level !== 3'd0 || a_if.underflow_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL fill_drained got %0d/%0d exp 0/0", a_if.fifo_level, a_if.underflow_cnt);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    a_if.enable = 1'b1;
    drive_a(1'b1, 6'h24);           // t=2 y=1 x=0 -> E4
    @(negedge clk);
    drive_a(1'b0, 6'h00);
    repeat (4) @(negedge clk);
    vectors++;
    if (a_if.word_strobe !== 1'b1 || a_if.word_out !== 8'hE4 || a_if.underflow_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL under_live got %b/%h/%0d exp 1/e4/0",
               a_if.word_strobe, a_if.word_out, a_if.underflow_cnt);
    end
    for (int i = 1; i <= 3; i++) begin
      repeat (4) @(negedge clk);
      vectors++;
      if (a_if.word_strobe !== 1'b1 || a_if.word_out !== HOLD_EXP ||
          a_if.underflow_cnt !== 8'(i)) begin
        miscompares++;
        $display("FAIL under_slot %0d got %b/%h/%0d exp 1/%h/%0d", i,
                 a_if.word_strobe, a_if.word_out, a_if.underflow_cnt, HOLD_EXP, i);
      end
    end
    a_if.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_underflow_saturate();
    apply_reset();
    b_if.enable = 1'b1;
    repeat (300) @(negedge clk);
    vectors++;
    if (b_if.underflow_cnt !== 8'hFF || b_if.word_strobe !== 1'b1 || b_if.word_out !== 8'h00) begin
      miscompares++;
      $display("FAIL under_saturate got %h/%b/%h exp ff/1/00",
               b_if.underflow_cnt, b_if.word_strobe, b_if.word_out);
    end
    b_if.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] str_s [8];
    logic [7:0] str_w [8];
    logic [7:0] exp_w;
    str_s = '{6'h01, 6'h12, 6'h23, 6'h30, 6'h0F, 6'h3C, 6'h2A, 6'h15};
    str_w = '{8'hC1, 8'hD2, 8'hE3, 8'hF0, 8'hCF, 8'hFC, 8'hEA, 8'hD5};
    exp_q.delete();
    apply_reset();
    b_if.enable = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) begin
        drive_b(1'b1, str_s[j]);
        exp_q.push_back(str_w[j]);
      end else begin
        drive_b(1'b0, 6'h00);
      end
      @(negedge clk);
      if (j >= 1) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        vectors++;
        if (b_if.word_strobe !== 1'b1 || b_if.word_out !== exp_w ||
            b_if.fifo_level !== ((j < 8) ? 3'd1 : 3'd0)) begin
          miscompares++;
          $display("FAIL b2b_word %0d got %b/%h/%0d exp 1/%h/%0d", j,
                   b_if.word_strobe, b_if.word_out, b_if.fifo_level, exp_w, (j < 8) ? 1 : 0);
        end
      end
    end
    b_if.enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (b_if.word_strobe !== 1'b0 || b_if.underflow_cnt !== 8'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_end got %b/%0d q%0d exp 0/0 q0",
               b_if.word_strobe, b_if.underflow_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_flush();
    logic [5:0] fl_s [4];
    fl_s = '{6'h11, 6'h22, 6'h33, 6'h3C};
    apply_reset();
    a_if.enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, fl_s[k]);
      @(negedge clk);
    end
    drive_a(1'b0, 6'h00);
    @(negedge clk);
    vectors++;
    if (a_if.word_out !== 8'hD1 || a_if.fifo_level !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre got %h/%0d exp d1/3", a_if.word_out, a_if.fifo_level);
    end
    reset       = 1'b1;
    a_if.enable = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_if.fifo_level !== 3'd0 || a_if.word_out !== 8'h00 || a_if.word_strobe !== 1'b0 ||
        a_if.underflow_cnt !== 8'd0 || a_state !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_reset got %0d/%h/%b/%0d/%b exp 0/00/0/0/0", a_if.fifo_level,
               a_if.word_out, a_if.word_strobe, a_if.underflow_cnt, a_state);
    end
    reset       = 1'b0;
    a_if.enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++;
      if (c < 5) begin
        if (a_if.word_strobe !== 1'b0 || a_if.word_out !== 8'h00) begin
          miscompares++;
          $display("FAIL flush_quiet cycle %0d got %b/%h exp 0/00", c, a_if.word_strobe, a_if.word_out);
        end
      end else begin
        if (a_if.word_strobe !== 1'b1 || a_if.word_out !== 8'h00 || a_if.underflow_cnt !== 8'd1) begin
          miscompares++;
          $display("FAIL flush_no_stale got %b/%h/%0d exp 1/00/1",
                   a_if.word_strobe, a_if.word_out, a_if.underflow_cnt);
        end
      end
    end
    a_if.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pause();
    apply_reset();
    drive_a(1'b1, 6'h05);
    @(negedge clk);
    drive_a(1'b1, 6'h3A);
    @(negedge clk);
    drive_a(1'b0, 6'h00);
    a_if.enable = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (a_if.word_strobe !== 1'b1 || a_if.word_out !== 8'hC5 || a_if.fifo_level !== 3'd1) begin
      miscompares++;
      $display("FAIL pause_first got %b/%h/%0d exp 1/c5/1",
               a_if.word_strobe, a_if.word_out, a_if.fifo_level);
    end
    a_if.enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (a_if.word_strobe !== 1'b0 || a_if.fifo_level !== 3'd1) begin
        miscompares++;
        $display("FAIL pause_hold cycle %0d got %b/%0d exp 0/1", c, a_if.word_strobe, a_if.fifo_level);
      end
    end
    a_if.enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vectors++;
      if (c < 5) begin
        if (a_if.word_strobe !== 1'b0) begin
          miscompares++;
          $display("FAIL pause_resume_early cycle %0d got %b exp 0", c, a_if.word_strobe);
        end
      end else begin
        if (a_if.word_strobe !== 1'b1 || a_if.word_out !== 8'hFA || a_if.underflow_cnt !== 8'd0) begin
          miscompares++;
          $display("FAIL pause_resume got %b/%h/%0d exp 1/fa/0",
                   a_if.word_strobe, a_if.word_out, a_if.underflow_cnt);
        end
      end
    end
    a_if.enable = 1'b0;
    @(negedge clk);
  endtask

  // Test sequence and final report
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    a_if.enable = 1'b0;
    b_if.enable = 1'b0;
    drive_a(1'b0, 6'h00);
    drive_b(1'b0, 6'h00);

    test_reset();
    test_single_live();
    test_fill_full();
    test_underflow();
    test_underflow_saturate();
    test_back_to_back();
    test_reset_flush();
    test_pause();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
